// File: rtl/imm_encode_pipe_pkg.sv
// Shared types and constants for the immediate encoder pipeline.
`timescale 1ns/1ps
package imm_encode_pipe_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 32;

  // Same encoding as the decoder immSrc select.
  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_J = 3'b011,
    FMT_U = 3'b100
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // One encode request as seen at the input handshake.
  typedef struct packed {
    logic [2:0]       fmt;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [IMM_W-1:0] imm;
  } imm_req_t;

  // True when imm[31:lsb] are all equal, i.e. the value survives sign extension from bit lsb.
  function automatic logic imm_fits(input logic [IMM_W-1:0] imm, input int unsigned lsb);
    logic [IMM_W-1:0] mask;
    mask = ~((IMM_W'(1) << lsb) - IMM_W'(1));
    return ((imm & mask) == mask) || ((imm & mask) == '0);
  endfunction

endpackage

// File: rtl/imm_encode_pipe_if.sv
// Request/response bundle between the command FIFO side and the imem write side.
`timescale 1ns/1ps
interface imm_encode_pipe_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ERR_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_pulse, err_count
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_pulse, err_count
  );
endinterface

// File: rtl/imm_pack.sv
// Combinational packer: request fields + immediate -> RV32 word and legality flag.
`timescale 1ns/1ps
module imm_pack
  import imm_encode_pipe_pkg::*;
(
  input  imm_req_t           req,
  output logic [INSTR_W-1:0] instr,
  output logic               legal
);

  // Scatter immediate bits into the format-specific fields and range-check them.
  always_comb begin
    instr = '0;
    legal = 1'b0;
    case (req.fmt)
      FMT_I: begin
        instr = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        legal = imm_fits(req.imm, 11);
      end
      FMT_S: begin
        instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
        legal = imm_fits(req.imm, 11);
      end
      FMT_B: begin
        instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                 req.imm[4:1], req.imm[11], req.opcode};
        legal = imm_fits(req.imm, 12) && !req.imm[0];
      end
      FMT_J: begin
        instr = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
        legal = imm_fits(req.imm, 20) && !req.imm[0];
      end
      FMT_U: begin
        instr = {req.imm[31:12], req.rd, req.opcode};
        legal = (req.imm[11:0] == 12'd0);
      end
      default: begin
        instr = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encode_pipe.sv
// Immediate encoder pipeline: packs requests into RV32 words and streams them with addresses.
`timescale 1ns/1ps
module imm_encode_pipe
  import imm_encode_pipe_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000),
  parameter int unsigned       ERR_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  imm_encode_pipe_if.slave bus
);

  imm_req_t           req_c;
  logic [INSTR_W-1:0] instr_c;
  logic               legal_c;
  logic               accept_c;
  logic               xfer_c;
  logic               reject_c;

  // Gather the request fields from the bus.
  always_comb begin
    req_c        = '0;
    req_c.fmt    = bus.in_fmt;
    req_c.opcode = bus.in_opcode;
    req_c.rd     = bus.in_rd;
    req_c.rs1    = bus.in_rs1;
    req_c.rs2    = bus.in_rs2;
    req_c.funct3 = bus.in_funct3;
    req_c.imm    = bus.in_imm;
  end

  imm_pack u_pack (
    .req   (req_c),
    .instr (instr_c),
    .legal (legal_c)
  );

  // Accept whenever the output slot is free or draining this cycle; flush blocks intake.
  assign bus.in_ready = !flush && (!bus.out_valid || bus.out_ready);
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign xfer_c       = bus.out_valid && bus.out_ready;
  assign reject_c     = accept_c && !legal_c;

  // Output word register: reload on a legal accept, drop on a drain, clear on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept_c && legal_c) begin
      bus.out_valid <= 1'b1;
      bus.out_instr <= instr_c;
    end else if (xfer_c) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Write address: step one word per completed transfer, rewind on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_addr <= BASE_ADDR;
    end else if (flush) begin
      bus.out_addr <= BASE_ADDR;
    end else if (xfer_c) begin
      bus.out_addr <= bus.out_addr + ADDR_W'(4);
    end
  end

  // Rejected-request pulse and saturating counter; flush leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err_pulse <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.err_pulse <= reject_c;
      if (reject_c && (bus.err_count != '1)) begin
        bus.err_count <= bus.err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: doc/imm_encode_pipe.md
Name: imm_encode_pipe

Overview:
- Inverse of the decode-stage immediate extender.
- Packs a 32-bit immediate and register/opcode fields into a legal RV32 instruction word for I/S/B/J/U formats, and range-checks the immediate.
- Streams accepted words to instruction-memory write logic with an auto-incrementing address.
- Used by the on-chip program loader and self-test generator, between the command FIFO and the imem write port.

Parameters:
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 32'h0000_0000, first write address after reset or flush.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of pipeline and address.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid & in_ready.
- in_fmt  input  3  000 I, 001 S, 010 B, 011 J, 100 U; others illegal; same encoding as the decoder immSrc.
- in_opcode  input  7  instr[6:0].
- in_rd  input  5  instr[11:7] for I/J/U; ignored for S/B.
- in_rs1  input  5  instr[19:15] for I/S/B.
- in_rs2  input  5  instr[24:20] for S/B.
- in_funct3  input  3  instr[14:12] for I/S/B.
- in_imm  input  32  full immediate value as the extender would output it.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  downstream accepts.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_W  write address for out_instr.
- err_pulse  output  1  one-cycle pulse on rejected request.
- err_count  output  ERR_W  saturating rejected-request count.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_pulse=0, err_count=0.
- Pipeline: single output register, latency 1 cycle from acceptance to out_valid.
- in_ready = !flush & (!out_valid | out_ready). This is combinational, so full throughput is possible.
- out_instr and out_addr hold stable while out_valid & !out_ready.
- Legality checks:
  - I/S: in_imm[31:11] all equal (signed 12-bit).
  - B: in_imm[31:12] all equal and in_imm[0]=0.
  - J: in_imm[31:20] all equal and in_imm[0]=0.
  - U: in_imm[11:0]=0.
  - Illegal fmt: always rejected.
- Packing for legal requests; bits not listed come from the in_* fields per the port list:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], rd, opcode.
  - U: [31:12]=imm[31:12], rd, opcode.
  - R-fields not used by a format come from the imm bits above, never from ports.
- Round-trip property: for every legal request, sign/zero extension per fmt of out_instr reproduces in_imm exactly. For U this means {out_instr[31:12],12'b0}==in_imm.
- Rejected request (accepted handshake, illegal):
  - No output word is produced.
  - out_valid is not set by it and out_addr does not advance.
  - err_pulse=1 the next cycle.
  - err_count increments, saturating at all-ones.
- Address:
  - out_addr advances by 4 on each out_valid & out_ready transfer.
  - Wraps modulo 2^ADDR_W, with no flag.
  - out_addr is the address of the word currently presented.
- flush:
  - Next cycle: out_valid=0, out_addr=BASE_ADDR.
  - err_count is kept.
  - in_ready=0 in the flush cycle, so no request is accepted.
  - A transfer coinciding with flush is discarded. Downstream must treat flush as an abort.
- Simultaneous output transfer and new acceptance: the register reloads with the new word and out_addr increments in the same edge.
- Reset mid-stream: all state returns to reset values immediately (async). Deassertion takes effect on the next clk edge.

Decomposition:
- Shared package (decode pkg): imm_fmt_e enum (FMT_I..FMT_U) with values matching the decoder immSrc encoding, and the opcode constants.
- Sub-module imm_pack: purely combinational fmt + imm + fields -> {instr, legal}. It is reused by the assertion bench for the round-trip check against the extender.
- Top level holds the handshake register, address counter and error counter.

Test Plan:
- I, imm=32'hFFFF_F800 (-2048), opcode 0010011, rd=1, rs1=2, funct3=0 -> out_instr=32'h8001_0093, out_addr=BASE_ADDR, latency 1.
- B, imm=32'h0000_0FFE -> [31]=0, [7]=1, [30:25]=6'h3F, [11:8]=4'hF. Next, B with imm=32'h0000_0001 -> rejected: err_pulse, err_count=1, no out_valid, address unchanged.
- J, imm=32'h000F_FFFE, then U with imm=32'h1234_5000 -> U gives out_instr[31:12]=20'h12345. The two words get addresses BASE and BASE+4.
- Back-to-back stream of 8 legal words with out_ready held low 3 cycles mid-stream -> out_instr/out_addr stable while stalled, no loss or duplication, final out_addr=BASE+28.
- flush asserted while out_valid & !out_ready with in_valid high -> next cycle out_valid=0, out_addr=BASE, request not accepted, err_count unchanged.
- 300 illegal requests with ERR_W=8 -> err_count saturates at 255. Random legal requests checked by the round-trip property against the extender.
